// File: rtl/pattern_persist_detector.sv
// Debounced pattern detector: synchronised AND/OR of monitored inputs, persistence-filtered match level.
// Optional event counter and sticky overflow flag are built when PATTERN_EVT_COUNTER_EN is defined.
module pattern_persist_detector #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 3,
    parameter int MODE  = 0
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    // state     | meaning
    // IDLE      | no match, raw_s low (or just returned low)
    // ARMING    | no match yet, counting consecutive raw_s highs
    // MATCH     | match asserted, raw_s high
    // RELEASING | match still asserted, counting consecutive raw_s lows
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        MATCH     = 2'd2,
        RELEASING = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] mon;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic             raw_d;
    logic             raw_s;
    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic             match_nxt;
    logic             match_q;
    logic             match_pulse;
    logic             rise;
    logic             unused_in;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign mon   = io_in[2 +: WIDTH];

    // bits above WIDTH are deliberately not monitored
    assign unused_in = ^io_in[7:2];

    assign raw_d = (MODE == 1) ? (|sync2) : (&sync2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            raw_s <= 1'b0;
        end else begin
            sync1 <= mon;
            sync2 <= sync1;
            raw_s <= raw_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (raw_s) begin
                    if (HOLD == 1) begin
                        state_nxt = MATCH;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = ARMING;
                        cnt_nxt   = 4'd1;
                    end
                end else begin
                    cnt_nxt = 4'd0;
                end
            end
            ARMING: begin
                if (!raw_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = MATCH;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            MATCH: begin
                if (!raw_s) begin
                    if (HOLD == 1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = RELEASING;
                        cnt_nxt   = 4'd1;
                    end
                end else begin
                    cnt_nxt = 4'd0;
                end
            end
            RELEASING: begin
                if (raw_s) begin
                    state_nxt = MATCH;
                    cnt_nxt   = 4'd0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // match_q and the pulse are registered from the next state so both appear on the edge the FSM enters MATCH
    assign match_nxt = (state_nxt == MATCH) || (state_nxt == RELEASING);
    assign rise      = match_nxt && !match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q     <= 1'b0;
            match_pulse <= 1'b0;
        end else begin
            match_q     <= match_nxt;
            match_pulse <= rise;
        end
    end

`ifdef PATTERN_EVT_COUNTER_EN
    logic [4:0] evt_cnt;
    logic       evt_ovf;

    // counter advances on the same edge that raises match_pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= 5'd0;
            evt_ovf <= 1'b0;
        end else if (rise) begin
            evt_cnt <= evt_cnt + 5'd1;
            if (evt_cnt == 5'd31) begin
                evt_ovf <= 1'b1;
            end
        end
    end

    assign io_out = {evt_ovf, evt_cnt, match_pulse, match_q};
`else
    assign io_out = {1'b0, {5{match_q}}, match_pulse, match_q};
`endif

endmodule

// File: tb/tb_pattern_persist_detector.sv
// Self-checking bench for pattern_persist_detector: directed table, hand sequences and random stimulus
// against a run-length reference model; three instances cover AND/OR reduction, WIDTH=6 and HOLD=1.
module tb_pattern_persist_detector;

    localparam int P_W [3] = '{4, 4, 6};
    localparam int P_H [3] = '{3, 3, 1};
    localparam int P_M [3] = '{0, 1, 0};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] din   = 6'd0;
    logic [7:0] io_in;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [7:0] out_c;

    assign io_in = {din, rst_n, clk};

    pattern_persist_detector #(.WIDTH(4), .HOLD(3), .MODE(0)) dut_a (.io_in(io_in), .io_out(out_a));
    pattern_persist_detector #(.WIDTH(4), .HOLD(3), .MODE(1)) dut_b (.io_in(io_in), .io_out(out_b));
    pattern_persist_detector #(.WIDTH(6), .HOLD(1), .MODE(0)) dut_c (.io_in(io_in), .io_out(out_c));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: inputs reach the filter three edges after being sampled; the match level flips
    // once HOLD consecutive filter samples disagree with it
    logic [5:0]  pipe [3];
    logic [15:0] hist [3];
    int          since [3];
    logic        m_match [3];
    logic        m_pulse [3];
    logic [4:0]  m_cnt [3];
    logic        m_ovf [3];

    typedef struct {
        logic [5:0] din;
        logic       m;
        logic       p;
    } vec_t;

    vec_t vec [49];

    function automatic logic reduce(input logic [5:0] v, input int w, input int mode);
        logic [5:0] mask;
        mask = 6'((1 << w) - 1);
        if (mode == 0) return (v & mask) == mask;
        return (v & mask) != 6'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pipe[k]    = 6'd0;
            hist[k]    = 16'd0;
            since[k]   = 0;
            m_match[k] = 1'b0;
            m_pulse[k] = 1'b0;
            m_cnt[k]   = 5'd0;
            m_ovf[k]   = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [5:0] d);
        logic        r;
        logic [15:0] hmask;
        for (int k = 0; k < 3; k++) begin
            r        = reduce(pipe[2], P_W[k], P_M[k]);
            hmask    = 16'((1 << P_H[k]) - 1);
            hist[k]  = {hist[k][14:0], r};
            if (since[k] < 15) since[k]++;
            m_pulse[k] = 1'b0;
            if (since[k] >= P_H[k] && (hist[k] & hmask) == (m_match[k] ? 16'h0000 : hmask)) begin
                m_match[k] = !m_match[k];
                since[k]   = 0;
                if (m_match[k]) begin
                    m_pulse[k] = 1'b1;
                    if (m_cnt[k] == 5'd31) m_ovf[k] = 1'b1;
                    m_cnt[k] = m_cnt[k] + 5'd1;
                end
            end
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = d;
    endtask

    function automatic logic [7:0] expect_out(input int k);
`ifdef PATTERN_EVT_COUNTER_EN
        return {m_ovf[k], m_cnt[k], m_pulse[k], m_match[k]};
`else
        return {1'b0, {5{m_match[k]}}, m_pulse[k], m_match[k]};
`endif
    endfunction

    function automatic logic [7:0] dut_out(input int k);
        case (k)
            0:       return out_a;
            1:       return out_b;
            default: return out_c;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_dut%0d", tag, k), dut_out(k), expect_out(k));
        end
    endtask

    task automatic step(input logic [5:0] d);
        din = d;
        @(posedge clk);
        model_edge(d);
        #1;
        check_all("model");
        @(negedge clk);
    endtask

    // enters from a negedge, asserts reset mid-cycle and checks the outputs clear without a clock edge
    task automatic apply_reset();
        din   = 6'd0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [0:48] em;
        logic [5:0]  seg_din [8];
        int          seg_len [8];
        int          idx;
        logic [5:0]  cur;
        logic [4:0]  exp_hi;

        seg_din = '{6'h0F, 6'h00, 6'h0F, 6'h07, 6'h0F, 6'h0E, 6'h0F, 6'h00};
        seg_len = '{8, 7, 2, 8, 8, 1, 7, 8};
        em      = {5'b0, 8'hFF, 17'b0, 16'hFFFF, 3'b0};
        idx     = 0;
        for (int s = 0; s < 8; s++) begin
            for (int j = 0; j < seg_len[s]; j++) begin
                vec[idx].din = seg_din[s];
                vec[idx].m   = em[idx];
                vec[idx].p   = (idx == 5) || (idx == 30);
                idx++;
            end
        end

        model_reset();
        rst_n = 1'b0;
        din   = 6'd0;
        #2;
        check_all("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table: latency, short burst, single-cycle drop from MATCH, release
        for (int i = 0; i < 49; i++) begin
            step(vec[i].din);
            check($sformatf("tbl_match_%0d", i), {7'd0, out_a[0]}, {7'd0, vec[i].m});
            check($sformatf("tbl_pulse_%0d", i), {7'd0, out_a[1]}, {7'd0, vec[i].p});
        end
`ifdef PATTERN_EVT_COUNTER_EN
        exp_hi = 5'd2;
`else
        exp_hi = 5'd0;
`endif
        check("tbl_count", {3'd0, out_a[6:2]}, {3'd0, exp_hi});

        // reset mid-ARMING and mid-MATCH: progress discarded, no pulse afterwards
        apply_reset();
        for (int i = 0; i < 4; i++) step(6'h0F);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(6'h00);
            check("no_pulse_after_rst_arming", out_a, 8'h00);
        end
        for (int i = 0; i < 7; i++) step(6'h0F);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(6'h00);
            check("no_pulse_after_rst_match", out_a, 8'h00);
        end

        // OR reduction latency with a single active bit
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            step(6'h04);
            check($sformatf("mode1_match_%0d", i), {7'd0, out_b[0]}, {7'd0, (i >= 5) ? 1'b1 : 1'b0});
        end

        // bits above WIDTH toggling alone must not create a match on the 4-bit instances
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 1) ? 6'h30 : 6'h00);
            check("upper_bits_a", out_a, 8'h00);
            check("upper_bits_b", out_b, 8'h00);
        end

        // 32 full match/release cycles wrap the event counter
        apply_reset();
        for (int s = 0; s < 32; s++) begin
            for (int i = 0; i < 6; i++) step(6'h0F);
            if (s == 0) begin
`ifdef PATTERN_EVT_COUNTER_EN
                exp_hi = 5'd1;
`else
                exp_hi = 5'h1F;
`endif
                check("first_match_hi", {3'd0, out_a[6:2]}, {3'd0, exp_hi});
                check("first_match_bit7", {7'd0, out_a[7]}, 8'd0);
            end
            for (int i = 0; i < 6; i++) step(6'h00);
        end
`ifdef PATTERN_EVT_COUNTER_EN
        check("wrap_count", {3'd0, out_a[6:2]}, 8'd0);
        check("wrap_ovf", {7'd0, out_a[7]}, 8'd1);
`else
        check("no_counter_bit7", {7'd0, out_a[7]}, 8'd0);
`endif
        apply_reset();
        check("ovf_cleared", out_a, 8'h00);

        // random stimulus with runs long enough to form matches, occasional resets
        cur = 6'd0;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 3) == 0) cur = 6'($urandom);
            if ($urandom_range(0, 199) == 0) apply_reset();
            step(cur);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
